// File: rtl/gf180_ram_bank_ctrl.sv
`timescale 1ns/1ps
// gf180_ram_bank_ctrl
// -------------------
// Bank controller for BANKS groups of four GF018 512x8 byte macros. Each
// group forms one 512x32 bank. The block decodes the upper word-address
// bits to a bank and expands the byte enables into per-bit active-low WEN.
// The macros have a one-cycle read latency, which this block wraps in a
// valid/ready request/response handshake with a response hold register.
// The macros themselves are instantiated outside this block.
//
// Ports
//   CLK, RESETn             clock, asynchronous active-low reset
//   REQ_VALID/REQ_READY     request handshake
//   REQ_WE, REQ_BE          1 = write; byte enables (bit i -> bits 8i+7:8i)
//   REQ_ADDR[AW-1:0]        [8:0] row, [AW-1:9] bank
//   REQ_WDATA[31:0]         write data
//   RSP_VALID/RSP_READY     read response handshake
//   RSP_RDATA[31:0]         read data (0 for an out-of-range bank)
//   RSP_ERR                 response belongs to an out-of-range bank
//   SRAM_CEN/GWEN[BANKS]    per-bank chip / global write enables, active low
//   SRAM_WEN[32*BANKS]      per-bit write enables, active low
//   SRAM_A[8:0], SRAM_D     shared row address and write data
//   SRAM_Q[32*BANKS]        macro read data, bank b at bits 32b+31:32b
module gf180_ram_bank_ctrl #(
  parameter int BANKS = 2,
  parameter int AW    = (BANKS > 1) ? 9 + $clog2(BANKS) : 9
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic                 REQ_WE,
  input  logic [3:0]           REQ_BE,
  input  logic [AW-1:0]        REQ_ADDR,
  input  logic [31:0]          REQ_WDATA,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [31:0]          RSP_RDATA,
  output logic                 RSP_ERR,
  output logic [BANKS-1:0]     SRAM_CEN,
  output logic [BANKS-1:0]     SRAM_GWEN,
  output logic [32*BANKS-1:0]  SRAM_WEN,
  output logic [8:0]           SRAM_A,
  output logic [31:0]          SRAM_D,
  input  logic [32*BANKS-1:0]  SRAM_Q
);

  // Width of the bank field; kept at least 1 so a single-bank build still
  // has a legal (constant zero) bank index.
  localparam int BKW = (AW > 9) ? AW - 9 : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [BKW-1:0]   bank_q, bank_d;
  logic             err_q, err_d;
  logic [31:0]      hold_data_q, hold_data_d;
  logic             hold_err_q, hold_err_d;

  logic [BKW-1:0]   req_bank;
  logic [31:0]      req_bank_ext;
  logic             in_range;
  logic             accept;
  logic             rd_accept;
  logic             access;
  logic [31:0]      q_sel;
  logic [31:0]      rd_data;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  generate
    if (AW > 9) begin : g_bank_field
      assign req_bank = REQ_ADDR[AW-1:9];
    end else begin : g_single_bank
      assign req_bank = '0;
    end
  endgenerate

  assign req_bank_ext = 32'(req_bank);
  assign in_range     = (req_bank_ext < $unsigned(BANKS));

  // REQ_READY is gated by RESETn so nothing is accepted while reset is held;
  // that also keeps every macro control deasserted during reset.
  assign REQ_READY = RESETn & ((state_q == ST_IDLE) | RSP_READY);
  assign accept    = REQ_VALID & REQ_READY;
  assign rd_accept = accept & ~REQ_WE;

  // A write with no byte enabled is accepted but never touches a macro.
  assign access = accept & in_range & (~REQ_WE | (|REQ_BE));

  assign SRAM_A = REQ_ADDR[8:0];
  assign SRAM_D = REQ_WDATA;

  // ---------------------------------------------------------------------
  // Per-bank macro controls, combinational from the accepted request so
  // the macros sample them on the accepting edge.
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
      logic hit;
      assign hit           = access & (req_bank == BKW'(gi));
      assign SRAM_CEN[gi]  = ~hit;
      assign SRAM_GWEN[gi] = ~(hit & REQ_WE);
      for (genvar gj = 0; gj < 4; gj++) begin : g_byte
        assign SRAM_WEN[32*gi + 8*gj +: 8] = {8{~(hit & REQ_WE & REQ_BE[gj])}};
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Read data path: select the Q of the bank registered at the read accept.
  // An out-of-range bank matches no entry and is also masked by err_q.
  // ---------------------------------------------------------------------
  always_comb begin
    q_sel = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (bank_q == BKW'(b)) begin
        q_sel = SRAM_Q[32*b +: 32];
      end
    end
  end

  assign rd_data = err_q ? 32'h0 : q_sel;

  // ---------------------------------------------------------------------
  // Response FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    err_d       = err_q;
    hold_data_d = hold_data_q;
    hold_err_d  = hold_err_q;

    // Bank and error flag track read accepts only; writes leave them alone
    // so an in-flight read response is not disturbed.
    if (rd_accept) begin
      bank_d = req_bank;
      err_d  = ~in_range;
    end

    case (state_q)
      ST_IDLE: begin
        if (rd_accept) begin
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (RSP_READY) begin
          state_d = rd_accept ? ST_RD : ST_IDLE;
        end else begin
          // Macro Q is only valid this cycle; capture it before stalling.
          state_d     = ST_HOLD;
          hold_data_d = rd_data;
          hold_err_d  = err_q;
        end
      end
      ST_HOLD: begin
        if (RSP_READY) begin
          state_d = rd_accept ? ST_RD : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Response FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    RSP_VALID = 1'b0;
    RSP_RDATA = '0;
    RSP_ERR   = 1'b0;
    case (state_q)
      ST_RD: begin
        RSP_VALID = 1'b1;
        RSP_RDATA = rd_data;
        RSP_ERR   = err_q;
      end
      ST_HOLD: begin
        RSP_VALID = 1'b1;
        RSP_RDATA = hold_data_q;
        RSP_ERR   = hold_err_q;
      end
      default: begin
        RSP_VALID = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= ST_IDLE;
      bank_q      <= '0;
      err_q       <= 1'b0;
      hold_data_q <= '0;
      hold_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      err_q       <= err_d;
      hold_data_q <= hold_data_d;
      hold_err_q  <= hold_err_d;
    end
  end

endmodule

// File: tb/tb_gf180_ram_bank_ctrl.sv
`timescale 1ns/1ps
// Testbench for gf180_ram_bank_ctrl. Two instances: BANKS=2 for the main
// traffic and BANKS=3 for out-of-range bank handling. Behavioural macro
// models sit on each SRAM port.
module tb_gf180_ram_bank_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- DUT A: BANKS = 2 ----------------
  logic        a_req_valid, a_req_ready, a_we;
  logic [3:0]  a_be;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic        a_rsp_valid, a_rsp_ready, a_err;
  logic [31:0] a_rdata;
  logic [1:0]  a_cen, a_gwen;
  logic [63:0] a_wen;
  logic [8:0]  a_sa;
  logic [31:0] a_sd;
  logic [63:0] a_q, a_q_model;
  logic        junk_en;
  logic [31:0] mem_a [2][512];

  assign a_q = junk_en ? {2{32'hBADC_0FFE}} : a_q_model;

  gf180_ram_bank_ctrl #(.BANKS(2)) dut_a (
    .CLK(clk), .RESETn(rst_n),
    .REQ_VALID(a_req_valid), .REQ_READY(a_req_ready), .REQ_WE(a_we),
    .REQ_BE(a_be), .REQ_ADDR(a_addr), .REQ_WDATA(a_wdata),
    .RSP_VALID(a_rsp_valid), .RSP_READY(a_rsp_ready),
    .RSP_RDATA(a_rdata), .RSP_ERR(a_err),
    .SRAM_CEN(a_cen), .SRAM_GWEN(a_gwen), .SRAM_WEN(a_wen),
    .SRAM_A(a_sa), .SRAM_D(a_sd), .SRAM_Q(a_q)
  );

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (!a_cen[b]) begin
        if (!a_gwen[b])
          mem_a[b][a_sa] <= (mem_a[b][a_sa] & a_wen[32*b +: 32]) | (a_sd & ~a_wen[32*b +: 32]);
        else
          a_q_model[32*b +: 32] <= mem_a[b][a_sa];
      end
    end
  end

  // ---------------- DUT B: BANKS = 3 ----------------
  logic        b_req_valid, b_req_ready, b_we;
  logic [3:0]  b_be;
  logic [10:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_err;
  logic [31:0] b_rdata;
  logic [2:0]  b_cen, b_gwen;
  logic [95:0] b_wen;
  logic [8:0]  b_sa;
  logic [31:0] b_sd;
  logic [95:0] b_q;
  logic [31:0] mem_b [3][512];

  gf180_ram_bank_ctrl #(.BANKS(3)) dut_b (
    .CLK(clk), .RESETn(rst_n),
    .REQ_VALID(b_req_valid), .REQ_READY(b_req_ready), .REQ_WE(b_we),
    .REQ_BE(b_be), .REQ_ADDR(b_addr), .REQ_WDATA(b_wdata),
    .RSP_VALID(b_rsp_valid), .RSP_READY(b_rsp_ready),
    .RSP_RDATA(b_rdata), .RSP_ERR(b_err),
    .SRAM_CEN(b_cen), .SRAM_GWEN(b_gwen), .SRAM_WEN(b_wen),
    .SRAM_A(b_sa), .SRAM_D(b_sd), .SRAM_Q(b_q)
  );

  always @(posedge clk) begin
    for (int b = 0; b < 3; b++) begin
      if (!b_cen[b]) begin
        if (!b_gwen[b])
          mem_b[b][b_sa] <= (mem_b[b][b_sa] & b_wen[32*b +: 32]) | (b_sd & ~b_wen[32*b +: 32]);
        else
          b_q[32*b +: 32] <= mem_b[b][b_sa];
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        dut;     // 0 = BANKS=2 instance, 1 = BANKS=3 instance
    logic        we;
    logic [3:0]  be;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [2:0]  cen;
    logic [2:0]  gwen;
    logic [95:0] wen;
    logic        rsp;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  localparam int NV = 19;
  localparam logic [31:0] W1 = 32'hFFFF_FFFF;
  localparam logic [31:0] W0 = 32'h0000_0000;
  vec_t vecs [NV];

  task automatic apply(input vec_t v, input int idx);
    @(posedge clk); #1;
    if (!v.dut) begin
      a_req_valid = 1'b1; a_we = v.we; a_be = v.be;
      a_addr = v.addr[9:0]; a_wdata = v.wdata;
    end else begin
      b_req_valid = 1'b1; b_we = v.we; b_be = v.be;
      b_addr = v.addr; b_wdata = v.wdata;
    end
    @(negedge clk);
    if (!v.dut) begin
      chk($sformatf("v%0d req_ready", idx), 96'(a_req_ready), 96'(1'b1));
      chk($sformatf("v%0d cen", idx), 96'(a_cen), 96'(v.cen[1:0]));
      chk($sformatf("v%0d gwen", idx), 96'(a_gwen), 96'(v.gwen[1:0]));
      chk($sformatf("v%0d wen", idx), 96'(a_wen), 96'(v.wen[63:0]));
      chk($sformatf("v%0d sram_a", idx), 96'(a_sa), 96'(v.addr[8:0]));
      if (v.we) chk($sformatf("v%0d sram_d", idx), 96'(a_sd), 96'(v.wdata));
    end else begin
      chk($sformatf("v%0d req_ready", idx), 96'(b_req_ready), 96'(1'b1));
      chk($sformatf("v%0d cen", idx), 96'(b_cen), 96'(v.cen));
      chk($sformatf("v%0d gwen", idx), 96'(b_gwen), 96'(v.gwen));
      chk($sformatf("v%0d wen", idx), b_wen, v.wen);
      chk($sformatf("v%0d sram_a", idx), 96'(b_sa), 96'(v.addr[8:0]));
    end
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    if (!v.dut) begin
      chk($sformatf("v%0d rsp_valid", idx), 96'(a_rsp_valid), 96'(v.rsp));
      if (v.rsp) begin
        chk($sformatf("v%0d rdata", idx), 96'(a_rdata), 96'(v.rdata));
        chk($sformatf("v%0d rsp_err", idx), 96'(a_err), 96'(v.err));
      end
      $display("vec %0d dut=A we=%0d be=%b addr=%h rsp=%0d rdata=%h err=%0d",
               idx, v.we, v.be, v.addr, a_rsp_valid, a_rdata, a_err);
    end else begin
      chk($sformatf("v%0d rsp_valid", idx), 96'(b_rsp_valid), 96'(v.rsp));
      if (v.rsp) begin
        chk($sformatf("v%0d rdata", idx), 96'(b_rdata), 96'(v.rdata));
        chk($sformatf("v%0d rsp_err", idx), 96'(b_err), 96'(v.err));
      end
      $display("vec %0d dut=B we=%0d be=%b addr=%h rsp=%0d rdata=%h err=%0d",
               idx, v.we, v.be, v.addr, b_rsp_valid, b_rdata, b_err);
    end
  endtask

  task automatic a_write(input logic [9:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    a_req_valid = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = addr; a_wdata = data;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
  endtask

  initial begin
    logic [9:0]  saddr;
    logic [31:0] sdata;

    for (int b = 0; b < 2; b++) for (int r = 0; r < 512; r++) mem_a[b][r] = '0;
    for (int b = 0; b < 3; b++) for (int r = 0; r < 512; r++) mem_b[b][r] = '0;
    a_q_model = '0; b_q = '0; junk_en = 1'b0;

    //            dut we  be     addr     wdata         cen     gwen    wen                rsp rdata         err
    vecs[0]  = '{1'b0,1'b1,4'hF,11'h005,32'hA5A5_1234,3'b110,3'b110,{W1,W1,W0},      1'b0,W0,           1'b0};
    vecs[1]  = '{1'b0,1'b0,4'hF,11'h005,W0,           3'b110,3'b111,{W1,W1,W1},      1'b1,32'hA5A5_1234,1'b0};
    vecs[2]  = '{1'b0,1'b1,4'hF,11'h205,W1,           3'b101,3'b101,{W1,W0,W1},      1'b0,W0,           1'b0};
    vecs[3]  = '{1'b0,1'b1,4'h5,11'h205,W0,           3'b101,3'b101,{W1,32'hFF00_FF00,W1},1'b0,W0,        1'b0};
    vecs[4]  = '{1'b0,1'b0,4'hF,11'h205,W0,           3'b101,3'b111,{W1,W1,W1},      1'b1,32'hFF00_FF00,1'b0};
    vecs[5]  = '{1'b0,1'b1,4'h0,11'h005,W0,           3'b111,3'b111,{W1,W1,W1},      1'b0,W0,           1'b0};
    vecs[6]  = '{1'b0,1'b0,4'hF,11'h005,W0,           3'b110,3'b111,{W1,W1,W1},      1'b1,32'hA5A5_1234,1'b0};
    vecs[7]  = '{1'b0,1'b1,4'hF,11'h3FF,32'h1111_2222,3'b101,3'b101,{W1,W0,W1},      1'b0,W0,           1'b0};
    vecs[8]  = '{1'b0,1'b0,4'hF,11'h3FF,W0,           3'b101,3'b111,{W1,W1,W1},      1'b1,32'h1111_2222,1'b0};
    vecs[9]  = '{1'b0,1'b1,4'hA,11'h1FF,32'h3333_4444,3'b110,3'b110,{W1,W1,32'h00FF_00FF},1'b0,W0,        1'b0};
    vecs[10] = '{1'b0,1'b0,4'hF,11'h1FF,W0,           3'b110,3'b111,{W1,W1,W1},      1'b1,32'h3300_4400,1'b0};
    vecs[11] = '{1'b1,1'b1,4'hF,11'h1FF,32'hB0B0_B0B0,3'b110,3'b110,{W1,W1,W0},      1'b0,W0,           1'b0};
    vecs[12] = '{1'b1,1'b1,4'hF,11'h3FF,32'hB1B1_B1B1,3'b101,3'b101,{W1,W0,W1},      1'b0,W0,           1'b0};
    vecs[13] = '{1'b1,1'b1,4'hF,11'h5FF,32'hB2B2_B2B2,3'b011,3'b011,{W0,W1,W1},      1'b0,W0,           1'b0};
    vecs[14] = '{1'b1,1'b0,4'hF,11'h7FF,W0,           3'b111,3'b111,{W1,W1,W1},      1'b1,W0,           1'b1};
    vecs[15] = '{1'b1,1'b1,4'hF,11'h7FF,32'h1234_5678,3'b111,3'b111,{W1,W1,W1},      1'b0,W0,           1'b0};
    vecs[16] = '{1'b1,1'b0,4'hF,11'h1FF,W0,           3'b110,3'b111,{W1,W1,W1},      1'b1,32'hB0B0_B0B0,1'b0};
    vecs[17] = '{1'b1,1'b0,4'hF,11'h3FF,W0,           3'b101,3'b111,{W1,W1,W1},      1'b1,32'hB1B1_B1B1,1'b0};
    vecs[18] = '{1'b1,1'b0,4'hF,11'h5FF,W0,           3'b011,3'b111,{W1,W1,W1},      1'b1,32'hB2B2_B2B2,1'b0};

    // Reset with a request pending: controls must stay idle.
    rst_n = 1'b0;
    a_req_valid = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 10'h005; a_wdata = '0;
    a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_we = 1'b0; b_be = 4'hF; b_addr = '0; b_wdata = '0;
    b_rsp_ready = 1'b1;
    #1;
    chk("rst rsp_valid", 96'(a_rsp_valid), 96'(1'b0));
    chk("rst rsp_err", 96'(a_err), 96'(1'b0));
    chk("rst req_ready", 96'(a_req_ready), 96'(1'b0));
    chk("rst cen", 96'(a_cen), 96'(2'b11));
    chk("rst gwen", 96'(a_gwen), 96'(2'b11));
    chk("rst wen", 96'(a_wen), 96'({W1, W1}));
    repeat (2) @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    rst_n = 1'b1;
    $display("reset released");

    for (int i = 0; i < NV; i++) apply(vecs[i], i);

    // Streaming: 8 back-to-back reads alternating banks.
    for (int k = 0; k < 8; k++) begin
      saddr = {k[0], 9'(9'h010 + 9'(k))};
      a_write(saddr, 32'hC0DE_0000 + 32'(k));
    end
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k > 0) begin
        sdata = 32'hC0DE_0000 + 32'(k - 1);
        chk($sformatf("stream%0d rsp_valid", k - 1), 96'(a_rsp_valid), 96'(1'b1));
        chk($sformatf("stream%0d rdata", k - 1), 96'(a_rdata), 96'(sdata));
        $display("stream rsp %0d rdata=%h", k - 1, a_rdata);
      end
      if (k < 8) begin
        chk($sformatf("stream%0d req_ready", k), 96'(a_req_ready), 96'(1'b1));
        saddr = {k[0], 9'(9'h010 + 9'(k))};
        a_req_valid = 1'b1; a_we = 1'b0; a_addr = saddr;
      end else begin
        a_req_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk("stream tail rsp_valid", 96'(a_rsp_valid), 96'(1'b0));

    // Stall: response held for 3 cycles while the macro output is junk.
    @(posedge clk); #1;
    a_req_valid = 1'b1; a_we = 1'b0; a_addr = 10'h005; a_rsp_ready = 1'b0;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    chk("stall rd rsp_valid", 96'(a_rsp_valid), 96'(1'b1));
    chk("stall rd rdata", 96'(a_rdata), 96'(32'hA5A5_1234));
    chk("stall rd req_ready", 96'(a_req_ready), 96'(1'b0));
    @(posedge clk); #1;
    junk_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall hold%0d rsp_valid", c), 96'(a_rsp_valid), 96'(1'b1));
      chk($sformatf("stall hold%0d rdata", c), 96'(a_rdata), 96'(32'hA5A5_1234));
      chk($sformatf("stall hold%0d req_ready", c), 96'(a_req_ready), 96'(1'b0));
      $display("stall cycle %0d rdata=%h", c, a_rdata);
      if (c < 2) begin
        @(posedge clk); #1;
      end
    end
    a_rsp_ready = 1'b1;
    #1;
    chk("stall release req_ready", 96'(a_req_ready), 96'(1'b1));
    @(posedge clk); #1;
    junk_en = 1'b0;
    chk("stall done rsp_valid", 96'(a_rsp_valid), 96'(1'b0));

    // Reset in the middle of a read response.
    @(posedge clk); #1;
    a_req_valid = 1'b1; a_we = 1'b0; a_addr = 10'h205;
    @(posedge clk); #1;
    chk("midrst rd rsp_valid", 96'(a_rsp_valid), 96'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst rsp_valid", 96'(a_rsp_valid), 96'(1'b0));
    chk("midrst cen", 96'(a_cen), 96'(2'b11));
    chk("midrst gwen", 96'(a_gwen), 96'(2'b11));
    chk("midrst wen", 96'(a_wen), 96'({W1, W1}));
    chk("midrst req_ready", 96'(a_req_ready), 96'(1'b0));
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    rst_n = 1'b1;
    $display("mid-read reset released");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post-rst%0d rsp_valid", c), 96'(a_rsp_valid), 96'(1'b0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
